// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: bus responder with a TX and an RX byte FIFO.
// Everything runs on CLK; uartRxPin is brought in through a 2-FF synchronizer.

module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

module uart_mmio #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteena,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq,
    input  logic        uartRxPin,
    output logic        uartTxPin
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef struct packed {
        tx_state_t tx;
        rx_state_t rx;
        logic      stall;
    } dbg_t;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;
    logic          tx_bit_end;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_full;
    logic          tx_empty;
    logic [7:0]    tx_dout;

    rx_state_t     rx_state;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_s3;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_bit_end;
    logic          rx_stop_tick;
    logic          rx_good;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_full;
    logic          rx_empty;
    logic [7:0]    rx_dout;

    logic          stall;
    logic          accept;
    logic          wr_en;
    logic          tx_wr;
    logic          tx_can_push;
    logic [1:0]    reg_sel;
    logic          overrun;
    logic          frame_err;
    logic          overrun_evt;
    logic          frame_evt;
    logic          clr_ov;
    logic          clr_fe;
    logic          tx_busy;
    logic [31:0]   status;
    dbg_t          dbg;
    logic          unused_sink;

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(CLK), .rst(RST), .push(tx_push), .pop(tx_pop),
        .din(wdata[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(CLK), .rst(RST), .push(rx_push), .pop(rx_pop),
        .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    // Handshake: a request is taken on an edge with req=1, ack=0 and no stalled
    // TX write; ack is a one-cycle pulse with rdata valid alongside it.
    assign reg_sel     = addr[3:2];
    assign accept      = req && !ack && !stall;
    assign wr_en       = we && byteena[0];
    assign tx_wr       = accept && wr_en && (reg_sel == 2'd0);
    assign tx_can_push = !tx_full || tx_pop;
    assign tx_push     = (tx_wr || stall) && tx_can_push;
    assign rx_pop      = accept && !we && (reg_sel == 2'd1) && !rx_empty;
    assign clr_ov      = accept && wr_en && (reg_sel == 2'd2) && wdata[3];
    assign clr_fe      = accept && wr_en && (reg_sel == 2'd2) && wdata[4];

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_pop     = !tx_empty && ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));
    assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty;

    assign rx_bit_end   = (rx_cnt == BIT_LAST);
    assign rx_stop_tick = (rx_state == RX_STOP) && rx_bit_end;
    assign rx_good      = rx_stop_tick && rx_s2;
    assign rx_push      = rx_good && (!rx_full || rx_pop);
    assign overrun_evt  = rx_good && rx_full && !rx_pop;
    assign frame_evt    = rx_stop_tick && !rx_s2;

    assign status = {27'd0, frame_err, overrun, tx_busy, tx_full, !rx_empty};
    assign irq    = !rx_empty;

    assign dbg         = '{tx: tx_state, rx: rx_state, stall: stall};
    assign unused_sink = ^{addr[1:0], wdata[31:8], byteena[3:1], dbg};

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            uartTxPin <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (tx_pop) begin
                        tx_shift  <= tx_dout;
                        tx_state  <= TX_START;
                        uartTxPin <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt    <= '0;
                        tx_idx    <= '0;
                        tx_state  <= TX_DATA;
                        uartTxPin <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_idx   <= tx_idx + 1'b1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_idx == 3'd7) begin
                            tx_state  <= TX_STOP;
                            uartTxPin <= 1'b1;
                        end else begin
                            uartTxPin <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit when more bytes wait.
                        if (tx_pop) begin
                            tx_shift  <= tx_dout;
                            tx_state  <= TX_START;
                            uartTxPin <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= uartRxPin;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_s3 && !rx_s2) rx_state <= RX_START;
                end
                RX_START: begin
                    // Half-bit re-check rejects glitches and aligns sampling to bit centres.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_idx   <= rx_idx + 1'b1;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ack       <= 1'b0;
            rdata     <= '0;
            stall     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ack   <= 1'b0;
            rdata <= '0;
            if (stall) begin
                if (tx_can_push) begin
                    stall <= 1'b0;
                    ack   <= 1'b1;
                end
            end else if (accept) begin
                if (tx_wr && !tx_can_push) stall <= 1'b1;
                else ack <= 1'b1;
                if (!we) begin
                    case (reg_sel)
                        2'd1:    rdata <= rx_empty ? 32'h0000_0100 : {24'd0, rx_dout};
                        2'd2:    rdata <= status;
                        default: rdata <= '0;
                    endcase
                end
            end
            // A new error event in the same cycle as a clear leaves the flag set.
            overrun   <= overrun_evt || (overrun && !clr_ov);
            frame_err <= frame_evt || (frame_err && !clr_fe);
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboarded bench for uart_mmio: bus reads are checked against a queue-based
// model of the RX FIFO and flags; a serial monitor decodes uartTxPin frames.
`timescale 1ns/1ps
module tb_uart_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byteena = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;
    logic        rx_pin = 1'b1;
    logic        tx_pin;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    bit          rd_q[$];
    logic [7:0]  tx_exp_q[$];
    int          tx_start_q[$];
    bit          tx_mon_en = 1'b1;

    logic [7:0]  m_rx[$];
    bit          m_ovr = 1'b0;
    bit          m_fe = 1'b0;

    uart_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .byteena(byteena), .rdata(rdata), .ack(ack), .irq(irq),
        .uartRxPin(rx_pin), .uartTxPin(tx_pin)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [31:0] status_exp(input logic [1:0] txb);
        return {27'd0, m_fe, m_ovr, txb, m_rx.size() != 0};
    endfunction

    function automatic logic [31:0] rxdata_exp();
        if (m_rx.size() == 0) return 32'h0000_0100;
        return {24'd0, m_rx.pop_front()};
    endfunction

    // driver tasks
    task automatic bus(input bit w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp_rd, input bit chk_lat, output int lat);
        @(negedge clk);
        exp_q.push_back(exp_rd);
        rd_q.push_back(!w);
        req = 1'b1; we = w; addr = a; wdata = d; byteena = be;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack !== 1'b1 && lat < 300);
        if (ack !== 1'b1) begin
            check("ack_timeout", {31'd0, ack}, 32'd1);
            void'(exp_q.pop_back());
            void'(rd_q.pop_back());
        end else if (chk_lat) begin
            check("ack_latency", lat, 32'd1);
        end
        req = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, input logic [1:0] txb);
        logic [31:0] e;
        int lat;
        case (a[3:2])
            2'd1:    e = rxdata_exp();
            2'd2:    e = status_exp(txb);
            default: e = 32'd0;
        endcase
        bus(1'b0, a, 32'd0, 4'b0000, e, 1'b1, lat);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                      input bit chk_lat, output int lat);
        if (be[0]) begin
            if (a[3:2] == 2'd0) tx_exp_q.push_back(d[7:0]);
            if (a[3:2] == 2'd2) begin
                if (d[3]) m_ovr = 1'b0;
                if (d[4]) m_fe = 1'b0;
            end
        end
        bus(1'b1, a, d, be, 32'd0, chk_lat, lat);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx_pin = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_pin = 1'b1;
        repeat (6) @(posedge clk);
        if (!stop) m_fe = 1'b1;
        else if (m_rx.size() < DEPTH) m_rx.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic glitch_rx();
        @(posedge clk);
        #1 rx_pin = 1'b0;
        @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    task automatic check_irq(input string name);
        @(negedge clk);
        check(name, {31'd0, irq}, {31'd0, m_rx.size() != 0});
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx_exp_q.size() != 0) begin
            check("tx_drain", tx_exp_q.size(), 32'd0);
            tx_exp_q.delete();
        end
        repeat (CPB) @(negedge clk);
    endtask

    // scoreboard: bus responses
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ack_spurious", {31'd0, ack}, 32'd0);
            end else begin
                logic [31:0] e;
                bit          r;
                e = exp_q.pop_front();
                r = rd_q.pop_front();
                if (r) check("rdata", rdata, e);
            end
        end
    end

    // serial monitor on uartTxPin
    initial begin : tx_mon
        int         st;
        logic [7:0] b;
        logic       s0;
        logic       sp;
        forever begin
            @(negedge clk);
            if (tx_pin === 1'b0) begin
                st = cyc;
                repeat (CPB / 2) @(negedge clk);
                s0 = tx_pin;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_pin;
                end
                repeat (CPB) @(negedge clk);
                sp = tx_pin;
                if (tx_mon_en) begin
                    tx_start_q.push_back(st);
                    check("tx_start_bit", {31'd0, s0}, 32'd0);
                    check("tx_stop_bit", {31'd0, sp}, 32'd1);
                    if (tx_exp_q.size() == 0) check("tx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
                    else check("tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
                end
            end
        end
    end

    initial begin : main
        int         lat;
        int         n;
        int         mism;
        logic [7:0] a5;
        logic       expb;
        logic [7:0] rb;

        do_reset();

        @(negedge clk);
        check("reset_tx_pin", {31'd0, tx_pin}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rd(4'h8, 2'b00);

        // single TX frame, exact waveform
        a5 = 8'hA5;
        wr(4'h0, 32'h0000_00A5, 4'b0001, 1'b1, lat);
        n = 0;
        while (tx_pin !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        mism = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i < CPB) expb = 1'b0;
            else if (i < 9 * CPB) expb = a5[(i - CPB) / CPB];
            else expb = 1'b1;
            if (tx_pin !== expb) mism++;
            @(negedge clk);
        end
        check("tx_a5_waveform_mismatches", mism, 32'd0);
        wait_tx_idle();

        // back-to-back TX writes until the FIFO fills and a write stalls
        tx_start_q.delete();
        for (int i = 0; i < 6; i++) begin
            wr(4'h0, $urandom_range(0, 255), 4'b0001, i == 0, lat);
            if (i == 5) begin
                check("tx_full_stall", {31'd0, lat > 1}, 32'd1);
                check("tx_stall_bound", {31'd0, lat <= 10 * CPB + 2}, 32'd1);
            end
        end
        rd(4'h8, 2'b11);
        wait_tx_idle();
        check("tx_frame_count", tx_start_q.size(), 32'd6);
        for (int i = 1; i < 6; i++) begin
            if (tx_start_q.size() > i) check("tx_frame_period", tx_start_q[i] - tx_start_q[i-1], 10 * CPB);
        end
        rd(4'h8, 2'b00);

        // single RX byte
        check_irq("irq_before_rx");
        send_rx(8'h3C, 1'b1);
        check_irq("irq_after_rx");
        rd(4'h4, 2'b00);
        check_irq("irq_after_pop");
        rd(4'h4, 2'b00);

        // overrun
        for (int v = 1; v <= 5; v++) send_rx(v[7:0], 1'b1);
        rd(4'h8, 2'b00);
        for (int i = 0; i < 5; i++) rd(4'h4, 2'b00);
        wr(4'h8, 32'h0000_0008, 4'b0001, 1'b1, lat);
        rd(4'h8, 2'b00);

        // framing error and glitch
        send_rx(8'h55, 1'b0);
        rd(4'h8, 2'b00);
        check_irq("irq_after_frame_err");
        glitch_rx();
        rd(4'h8, 2'b00);
        check_irq("irq_after_glitch");
        wr(4'h8, 32'h0000_0010, 4'b0001, 1'b1, lat);
        rd(4'h8, 2'b00);

        // randomized mix
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 6))
                0, 1: begin
                    rb = 8'($urandom_range(0, 255));
                    send_rx(rb, $urandom_range(0, 5) != 0);
                    check_irq("irq_random");
                end
                2: rd(4'h4, 2'b00);
                3: begin
                    wait_tx_idle();
                    rd(4'h8, 2'b00);
                end
                4: wr(4'h8, {27'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd0},
                      {3'b000, 1'($urandom_range(0, 1))}, 1'b1, lat);
                5: wr(4'h0, $urandom_range(0, 255), 4'b0001, 1'b0, lat);
                default: begin
                    rd(4'hC, 2'b00);
                    rd(4'h0, 2'b00);
                    wr(4'hC, $urandom, 4'b1111, 1'b1, lat);
                    wr(4'h4, $urandom, 4'b1111, 1'b1, lat);
                    wr(4'h0, $urandom, 4'b1110, 1'b1, lat);
                end
            endcase
        end
        wait_tx_idle();
        rd(4'h8, 2'b00);

        // reset in the middle of a TX frame
        tx_mon_en = 1'b0;
        wr(4'h0, 32'h0000_0000, 4'b0001, 1'b1, lat);
        repeat (12) @(negedge clk);
        check("tx_low_before_reset", {31'd0, tx_pin}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("tx_pin_after_reset", {31'd0, tx_pin}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tx_exp_q.delete();
        m_rx.delete();
        m_ovr = 1'b0;
        m_fe = 1'b0;
        repeat (2) @(negedge clk);
        check("tx_pin_idle_after_reset", {31'd0, tx_pin}, 32'd1);
        rd(4'h8, 2'b00);
        check_irq("irq_after_reset");

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
